controle_multiciclo: RTL



---
 rtl/controle_pkg.sv | 59 +++++
 rtl/controle_ula_dec.sv | 22 ++
 rtl/controle_multiciclo.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/controle_pkg.sv
// Shared encodings for the multicycle MIPS-16 control: opcodes, FSM states,
// ALU operation codes and datapath select values.
package controle_pkg;

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_LW   = 4'b0010;
  localparam logic [3:0] OP_SW   = 4'b0011;
  localparam logic [3:0] OP_BEQ  = 4'b0100;
  localparam logic [3:0] OP_BNE  = 4'b0101;
  localparam logic [3:0] OP_J    = 4'b0110;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_EXEC_I    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11
  } state_t;

  // Must stay bit-identical to the ALU's operation decode.
  localparam logic [2:0] ULA_ADD   = 3'b000;
  localparam logic [2:0] ULA_SUB   = 3'b001;
  localparam logic [2:0] ULA_AND   = 3'b010;
  localparam logic [2:0] ULA_OR    = 3'b011;
  localparam logic [2:0] ULA_MENOR = 3'b100;
  localparam logic [2:0] ULA_XOR   = 3'b101;
  localparam logic [2:0] ULA_SLL   = 3'b110;
  localparam logic [2:0] ULA_SRL   = 3'b111;

  localparam logic [1:0] SRC_B_REG = 2'b00;
  localparam logic [1:0] SRC_B_ONE = 2'b01;
  localparam logic [1:0] SRC_B_IMM = 2'b10;
  localparam logic [1:0] SRC_B_BR  = 2'b11;

  localparam logic [1:0] PC_SRC_ULA    = 2'b00;
  localparam logic [1:0] PC_SRC_ULAOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  function automatic logic is_legal_opcode(input logic [3:0] op);
    case (op)
      OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: return 1'b1;
      default:                                           return 1'b0;
    endcase
  endfunction

  // States that talk to memory and may be stretched by wait cycles.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/controle_ula_dec.sv
// ALU operation decode: selects the 3-bit ALU op from the control state and
// the R-type funct field. Only defined codes are ever produced.
module controle_ula_dec
  import controle_pkg::*;
(
  input  logic [3:0] state,
  input  logic [2:0] funct,
  output logic [2:0] ula_control
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    ula_control = ULA_ADD;
    case (state)
      S_EXEC_R: ula_control = funct;
      S_BRANCH: ula_control = ULA_SUB;
      default:  ula_control = ULA_ADD;
    endcase
  end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle main control FSM for the 16-bit MIPS datapath: sequences
// fetch/decode/execute/memory/writeback and drives all datapath controls.
module controle_multiciclo
  import controle_pkg::*;
#(
  parameter int MEM_WAIT = 0,
  parameter int STATE_W  = 4
)(
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         opcode,
  input  logic [2:0]         funct,
  input  logic               zero,
  output logic               pc_en,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               ula_src_a,
  output logic [1:0]         ula_src_b,
  output logic [2:0]         ula_control,
  output logic [1:0]         pc_source,
  output logic               illegal,
  output logic [STATE_W-1:0] estado
);

  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

  state_t     state;
  state_t     next_state;
  logic [2:0] wait_cnt;
  logic       wait_done;
  logic [3:0] dec_state;

  assign wait_done = (wait_cnt == WAIT_LAST);

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:     next_state = wait_done ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_R:          next_state = S_EXEC_R;
          OP_ADDI:       next_state = S_EXEC_I;
          OP_LW, OP_SW:  next_state = S_MEM_ADDR;
          OP_BEQ, OP_BNE: next_state = S_BRANCH;
          OP_J:          next_state = S_JUMP;
          default:       next_state = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  next_state = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  next_state = wait_done ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: next_state = wait_done ? S_FETCH : S_MEM_WRITE;
      S_MEM_WB:    next_state = S_FETCH;
      S_EXEC_R:    next_state = S_R_WB;
      S_EXEC_I:    next_state = S_I_WB;
      default:     next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      if (next_state != state)
        wait_cnt <= '0;
      else if (is_mem_state(state) && !wait_done)
        wait_cnt <= wait_cnt + 3'd1;
    end
  end

  // Reset forces the decoder to FETCH so the ALU sees the fetch op.
  assign dec_state = reset ? S_FETCH : state;

  controle_ula_dec u_ula_dec (
    .state       (dec_state),
    .funct       (funct),
    .ula_control (ula_control)
  );

  always_comb begin
    pc_en      = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    ula_src_a  = 1'b0;
    ula_src_b  = SRC_B_REG;
    pc_source  = PC_SRC_ULA;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        ula_src_b = SRC_B_ONE;
        ir_write  = wait_done;
        pc_en     = wait_done;
      end
      S_DECODE: begin
        ula_src_b = SRC_B_BR;
        illegal   = !is_legal_opcode(opcode);
      end
      S_MEM_ADDR, S_EXEC_I: begin
        ula_src_a = 1'b1;
        ula_src_b = SRC_B_IMM;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_EXEC_R: ula_src_a = 1'b1;
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_I_WB: reg_write = 1'b1;
      S_BRANCH: begin
        ula_src_a = 1'b1;
        pc_source = PC_SRC_ULAOUT;
        pc_en     = (opcode == OP_BNE) ? ~zero : zero;
      end
      S_JUMP: begin
        pc_source = PC_SRC_JUMP;
        pc_en     = 1'b1;
      end
      default: ;
    endcase

    // While reset is held: strobes off, selects at their FETCH values.
    if (reset) begin
      pc_en      = 1'b0;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      ula_src_a  = 1'b0;
      ula_src_b  = SRC_B_ONE;
      pc_source  = PC_SRC_ULA;
      illegal    = 1'b0;
    end
  end

  assign estado = reset ? '0 : STATE_W'(state);

endmodule
